// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state type and sizing helper for the
// bit-serial subtractor.
package arith_pkg;

   // Operation phases of the bit-serial subtractor.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sub_state_e;

   // Bit-counter width: must hold the values 0..w.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master: producer of operands and consumer of results (testbench side).
// slave:  the subtractor itself.
interface serial_subtractor_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH:0]   X;
   logic [DATA_WIDTH-1:0] A;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] B;
   logic                  underflow;
   logic                  overflow;

   modport master (
      output in_valid, X, A, out_ready,
      input  in_ready, out_valid, B, underflow, overflow
   );

   modport slave (
      input  in_valid, X, A, out_ready,
      output in_ready, out_valid, B, underflow, overflow
   );
endinterface

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor cell: d = x - a - borrow_in, with borrow out.
module sub_bit_cell (
   input  logic x,
   input  logic a,
   input  logic borrow_in,
   output logic d,
   output logic borrow_out
);

   // Difference bit and borrow propagation for a single bit position.
   always_comb begin
      d          = x ^ a ^ borrow_in;
      borrow_out = (~x & a) | (~(x ^ a) & borrow_in);
   end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: B = X - A, one bit per clock, LSB first.
// X is DATA_WIDTH+1 bits, A is DATA_WIDTH bits (zero-extended internally).
// Build option: define SERIAL_SUBTRACTOR_SAT_EN to saturate B (0 on underflow,
// all-ones on overflow); otherwise B is the wrapped low DATA_WIDTH bits.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor_if.slave   bus
);

   localparam int                CNT_W    = cnt_width(DATA_WIDTH);
   localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH);

   sub_state_e            state_q, state_d;
   logic [DATA_WIDTH:0]   x_q, x_d;
   logic [DATA_WIDTH:0]   a_q, a_d;
   logic [DATA_WIDTH:0]   res_q, res_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  borrow_q, borrow_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic                  uf_q, uf_d;
   logic                  of_q, of_d;

   logic                  cell_d;
   logic                  cell_borrow;
   logic [DATA_WIDTH:0]   res_next;
   logic [DATA_WIDTH-1:0] b_final;
   logic                  uf_final;
   logic                  of_final;

   // Operand LSBs sit at bit 0 of the shift registers.
   sub_bit_cell u_cell (
      .x          (x_q[0]),
      .a          (a_q[0]),
      .borrow_in  (borrow_q),
      .d          (cell_d),
      .borrow_out (cell_borrow)
   );

   // Result formatting, valid on the last RUN cycle when cell_d is the top bit.
   always_comb begin
      res_next = {cell_d, res_q[DATA_WIDTH:1]};
      uf_final = cell_borrow;
      of_final = cell_d & ~cell_borrow;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      if (uf_final) begin
         b_final = '0;
      end else if (of_final) begin
         b_final = '1;
      end else begin
         b_final = res_next[DATA_WIDTH-1:0];
      end
`else
      b_final = res_next[DATA_WIDTH-1:0];
`endif
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      a_d      = a_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      b_d      = b_q;
      uf_d     = uf_q;
      of_d     = of_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d      = bus.X;
               a_d      = {1'b0, bus.A};
               res_d    = '0;
               cnt_d    = '0;
               borrow_d = 1'b0;
               state_d  = RUN;
            end
         end
         RUN: begin
            x_d      = x_q >> 1;
            a_d      = a_q >> 1;
            res_d    = res_next;
            borrow_d = cell_borrow;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               b_d     = b_final;
               uf_d    = uf_final;
               of_d    = of_final;
               state_d = DONE;
            end
         end
         DONE: begin
            // Returning to IDLE here means new operands are seen a cycle later.
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         x_q      <= '0;
         a_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         b_q      <= '0;
         uf_q     <= 1'b0;
         of_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         a_q      <= a_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         b_q      <= b_d;
         uf_q     <= uf_d;
         of_q     <= of_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.B         = b_q;
   assign bus.underflow = uf_q;
   assign bus.overflow  = of_q;

   // A waiting result must not change until it is taken.
   a_done_hold : assert property (@(posedge clk) disable iff (rst)
      (state_q == DONE && !bus.out_ready) |=>
         (state_q == DONE && $stable(b_q) && $stable(uf_q) && $stable(of_q)));

   // Overflow and underflow are mutually exclusive.
   a_flags_excl : assert property (@(posedge clk) disable iff (rst)
      !(uf_q && of_q));

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at DATA_WIDTH=4.
module tb_serial_subtractor;

   logic clk;
   logic rst;
   int   tests_run;
   int   tests_failed;

   serial_subtractor_if #(.DATA_WIDTH(4)) bus ();

   serial_subtractor #(.DATA_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
   localparam logic [3:0] EXP_B_2_5  = 4'h0;
   localparam logic [3:0] EXP_B_16_0 = 4'hF;
   localparam logic [3:0] EXP_B_20_4 = 4'hF;
`else
   localparam logic [3:0] EXP_B_2_5  = 4'hD;
   localparam logic [3:0] EXP_B_16_0 = 4'h0;
   localparam logic [3:0] EXP_B_20_4 = 4'h0;
`endif

   // Presents operands for one edge (caller ensures IDLE), then drops in_valid.
   task automatic start_op(input logic [4:0] x, input logic [3:0] a);
      bus.X        = x;
      bus.A        = a;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Counts cycles from the accepting edge until out_valid, bounded.
   task automatic wait_done(output int cyc, output bit timed_out);
      cyc       = 0;
      timed_out = 1'b0;
      while (!bus.out_valid) begin
         if (cyc >= 20) begin
            timed_out = 1'b1;
            return;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.X         = '0;
      bus.A         = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL reset_hs: got in_ready/out_valid=%b want 10",
                  {bus.in_ready, bus.out_valid});
      end
      tests_run++;
      if ({bus.B, bus.underflow, bus.overflow} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_out: got B/uf/of=%b want 000000",
                  {bus.B, bus.underflow, bus.overflow});
      end
   endtask

   task automatic test_basic();
      int cyc;
      bit to;
      start_op(5'd9, 4'd3);
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_busy: got in_ready=%b want 0", bus.in_ready);
      end
      wait_done(cyc, to);
      tests_run++;
      if (to || cyc != 5) begin
         tests_failed++;
         $display("FAIL basic_latency: got %0d cycles (timeout=%0b) want 5", cyc, to);
      end
      tests_run++;
      if ({bus.B, bus.underflow, bus.overflow} !== {4'h6, 2'b00}) begin
         tests_failed++;
         $display("FAIL basic_9_3: got B=%h uf=%b of=%b want B=6 uf=0 of=0",
                  bus.B, bus.underflow, bus.overflow);
      end
      consume();
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL basic_release: got in_ready/out_valid=%b want 10",
                  {bus.in_ready, bus.out_valid});
      end
   endtask

   task automatic test_flags();
      int cyc;
      bit to;
      logic [4:0] xs [6] = '{5'd2, 5'd31, 5'd16, 5'd7, 5'd10, 5'd20};
      logic [3:0] as [6] = '{4'd5, 4'd0, 4'd0, 4'd7, 4'd0, 4'd4};
      logic [5:0] ex [6] = '{{EXP_B_2_5, 2'b10}, {4'hF, 2'b01}, {EXP_B_16_0, 2'b01},
                             {4'h0, 2'b00}, {4'hA, 2'b00}, {EXP_B_20_4, 2'b01}};
      for (int i = 0; i < 6; i++) begin
         start_op(xs[i], as[i]);
         wait_done(cyc, to);
         tests_run++;
         if (to || {bus.B, bus.underflow, bus.overflow} !== ex[i]) begin
            tests_failed++;
            $display("FAIL flags_%0d_%0d: got B/uf/of=%b (timeout=%0b) want %b",
                     xs[i], as[i], {bus.B, bus.underflow, bus.overflow}, to, ex[i]);
         end
         consume();
      end
   endtask

   task automatic test_hold();
      int cyc;
      bit to;
      start_op(5'd12, 4'd5);
      wait_done(cyc, to);
      for (int i = 0; i < 3; i++) begin
         // A stray operand pulse while the result waits must be dropped.
         bus.X        = 5'd1;
         bus.A        = 4'd1;
         bus.in_valid = (i == 1);
         @(posedge clk);
         #1;
         tests_run++;
         if (to || {bus.out_valid, bus.in_ready, bus.B, bus.underflow, bus.overflow}
                   !== {2'b10, 4'h7, 2'b00}) begin
            tests_failed++;
            $display("FAIL hold_%0d: got ov/ir/B/uf/of=%b want 10011100", i,
                     {bus.out_valid, bus.in_ready, bus.B, bus.underflow, bus.overflow});
         end
      end
      bus.in_valid = 1'b0;
      consume();
      repeat (7) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL hold_no_queue: got in_ready/out_valid=%b want 10",
                  {bus.in_ready, bus.out_valid});
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit to;
      start_op(5'd8, 4'd8);
      wait_done(cyc, to);
      // Next operands already valid on the consuming edge.
      bus.X         = 5'd20;
      bus.A         = 4'd6;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL b2b_no_same_cycle: got in_ready/out_valid=%b want 10",
                  {bus.in_ready, bus.out_valid});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL b2b_accept: got in_ready=%b want 0", bus.in_ready);
      end
      wait_done(cyc, to);
      tests_run++;
      if (to || cyc != 5 || {bus.B, bus.underflow, bus.overflow} !== {4'hE, 2'b00}) begin
         tests_failed++;
         $display("FAIL b2b_20_6: got B=%h uf=%b of=%b cyc=%0d want B=e uf=0 of=0 cyc=5",
                  bus.B, bus.underflow, bus.overflow, cyc);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      int cyc;
      bit to;
      start_op(5'd9, 4'd3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL rstmid_async: got in_ready/out_valid=%b want 10",
                  {bus.in_ready, bus.out_valid});
      end
      #2;
      rst = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         tests_failed++;
         $display("FAIL rstmid_abandon: got in_ready/out_valid=%b want 10",
                  {bus.in_ready, bus.out_valid});
      end
      start_op(5'd16, 4'd1);
      wait_done(cyc, to);
      tests_run++;
      if (to || {bus.B, bus.underflow, bus.overflow} !== {4'hF, 2'b00}) begin
         tests_failed++;
         $display("FAIL rstmid_16_1: got B=%h uf=%b of=%b want B=f uf=0 of=0",
                  bus.B, bus.underflow, bus.overflow);
      end
      consume();
   endtask

   task automatic test_round_trip();
      int         cyc;
      bit         to;
      logic [4:0] sum;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            sum = 5'(a) + 5'(b);
            start_op(sum, 4'(a));
            wait_done(cyc, to);
            tests_run++;
            if (to || {bus.B, bus.underflow, bus.overflow} !== {4'(b), 2'b00}) begin
               tests_failed++;
               $display("FAIL rt_%0d_%0d: got B=%h uf=%b of=%b want B=%h uf=0 of=0",
                        a, b, bus.B, bus.underflow, bus.overflow, 4'(b));
            end
            consume();
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_basic();
      test_flags();
      test_hold();
      test_back_to_back();
      test_reset_mid();
      test_round_trip();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no completion want finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4, giving operand A / result B width; minuend X is DATA_WIDTH+1 bits wide.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operands X/A present.
REQ-005 SHALL have port in_ready  output  1  block accepts operands.
REQ-006 SHALL have port X  input  DATA_WIDTH+1  unsigned minuend (sum-width operand).
REQ-007 SHALL have port A  input  DATA_WIDTH  unsigned subtrahend.
REQ-008 SHALL have port out_valid  output  1  result B and flags valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port B  output  DATA_WIDTH  result X-A (see REQ-020).
REQ-011 SHALL have port underflow  output  1  X < A.
REQ-012 SHALL have port overflow  output  1  X-A >= 2**DATA_WIDTH.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-014 SHALL, in IDLE with in_valid=1 at a posedge, latch X, zero-extend and latch A, clear bit counter and borrow, and enter RUN; in_valid=0 keeps IDLE.
REQ-015 SHALL, in RUN, process one bit per cycle LSB first: d = x^a^borrow; borrow' = (~x&a) | (~(x^a)&borrow); d shifted into result register.
REQ-016 SHALL stay in RUN exactly DATA_WIDTH+1 cycles, then enter DONE; out_valid rises DATA_WIDTH+1 cycles after the accepting edge (5 cycles at DATA_WIDTH=4).
REQ-017 SHALL hold B, underflow, overflow stable in DONE until out_ready=1 at a posedge, then return to IDLE.
REQ-018 SHALL NOT accept operands in the same cycle a result is consumed; next acceptance earliest one cycle after DONE->IDLE.
REQ-019 SHALL ignore in_valid while in RUN or DONE (no queuing, X/A changes have no effect).
REQ-020 SHALL set underflow = final borrow; overflow = result bit DATA_WIDTH AND NOT underflow; B = result[DATA_WIDTH-1:0] unless modified by REQ-025.
REQ-021 SHALL produce underflow=0, overflow=0 for X==A (B=0) and for A=0 with X<2**DATA_WIDTH (B=X).

Reset
REQ-022 SHALL, on rst=1, asynchronously enter IDLE and clear B, underflow, overflow, out_valid, counter, borrow; in_ready=1 while in IDLE after rst=0.
REQ-023 SHALL abandon any RUN/DONE operation on reset mid-operation; no result is emitted for it.

Configuration
REQ-024 SHALL honour macro SERIAL_SUBTRACTOR_SAT_EN.
REQ-025 SHALL, with SERIAL_SUBTRACTOR_SAT_EN defined, saturate B: 0 on underflow, all-ones on overflow; flags unchanged.
REQ-026 SHALL, without SERIAL_SUBTRACTOR_SAT_EN, output two's-complement wrapped B (low DATA_WIDTH bits).

Structure
REQ-027 SHALL place the FSM state enum typedef (IDLE/RUN/DONE) in shared package arith_pkg.
REQ-028 SHALL instantiate one combinational sub-module sub_bit_cell (inputs x, a, borrow_in; outputs d, borrow_out) for the per-bit step.
REQ-029 SHALL size the bit counter as $clog2(DATA_WIDTH+2) bits.

Verification (DATA_WIDTH=4)
REQ-030 SHALL cover X=9, A=3 -> B=6, underflow=0, overflow=0, out_valid 5 cycles after accept.
REQ-031 SHALL cover X=2, A=5 -> underflow=1, B=4'hD (wrap) / 4'h0 (SAT_EN).
REQ-032 SHALL cover X=31, A=0 -> overflow=1, B=4'hF in both modes; X=16, A=0 -> overflow=1, B=0 (wrap) / 4'hF (SAT_EN).
REQ-033 SHALL cover out_ready low 3 cycles in DONE -> B/flags held, in_ready=0, in_valid pulse during hold ignored.
REQ-034 SHALL cover rst pulse in 2nd RUN cycle -> out_valid=0, in_ready=1; then X=16, A=1 -> B=15, no flags.
REQ-035 SHALL cover exhaustive round-trip: X = A+B from the team's registered adder for all 4-bit A,B -> recovered B matches, underflow=0, overflow=0.
